// File: rtl/affine_ctrl_pkg.sv
// rtl/affine_ctrl_pkg.sv - shared types and helpers for the affine loop controller
package affine_ctrl_pkg;

  localparam int NUM_LOOPS     = 3;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index [0] is the outermost loop, [2] the innermost.
  typedef logic [NUM_LOOPS-1:0][DEFAULT_WIDTH-1:0] ctrl_vars_t;

  function automatic bit fits_width(input int value, input int width);
    return (value >= 0) && (longint'(value) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/affine_ctrl_counter.sv
// rtl/affine_ctrl_counter.sv - one loop dimension: counts on inc_i, wraps at EXT-1, flags carry
module affine_ctrl_counter
#(
  parameter int WIDTH = 16,
  parameter int EXT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(EXT - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == LAST);
  assign carry_o = inc_i && at_last;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/affine_loop_ctrl.sv
// rtl/affine_loop_ctrl.sv - walks a 3-deep loop nest on a fixed schedule for one buffer port
// Optional flattened address output is enabled by defining AFFINE_CTRL_ADDR_EN.
module affine_loop_ctrl
  import affine_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int EXT_0       = 1,
  parameter int EXT_1       = 128,
  parameter int EXT_2       = 128,
  parameter int II          = 1,
  parameter int START_DELAY = 0,
  parameter int SHIFT_1     = 1,
  parameter int SHIFT_2     = 1,
  parameter int ROW_STRIDE  = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            stall,
  output logic                            en,
  output logic [NUM_LOOPS-1:0][WIDTH-1:0] ctrl_vars,
  output logic                            done
`ifdef AFFINE_CTRL_ADDR_EN
  ,
  output logic [WIDTH-1:0]                addr
`endif
);

  localparam logic [WIDTH-1:0] II_M1    = WIDTH'(II - 1);
  localparam logic [WIDTH-1:0] DELAY_LD = WIDTH'(START_DELAY);

  if (EXT_0 < 1 || EXT_1 < 1 || EXT_2 < 1 || II < 1 || START_DELAY < 0) begin : g_bad_range
    $error("affine_loop_ctrl: EXT_n and II must be >= 1 and START_DELAY >= 0");
  end

  if (!fits_width(EXT_0 - 1, WIDTH) || !fits_width(EXT_1 - 1, WIDTH) ||
      !fits_width(EXT_2 - 1, WIDTH) || !fits_width(II - 1, WIDTH) ||
      !fits_width(START_DELAY, WIDTH)) begin : g_bad_width
    $error("affine_loop_ctrl: loop extents or schedule do not fit in WIDTH bits");
  end

  state_e                            state_q;
  logic [WIDTH-1:0]                  delay_q;
  logic [WIDTH-1:0]                  ii_q;
  logic                              en_q;
  logic                              done_q;
  logic [NUM_LOOPS-1:0][WIDTH-1:0]   cv_q;

  logic [WIDTH-1:0] cnt_0, cnt_1, cnt_2;
  logic             carry_0, carry_1, carry_2;
  logic             due, issue;

  assign due   = ((state_q == DELAY) && (delay_q == '0)) ||
                 ((state_q == RUN)   && (ii_q == '0));
  assign issue = due && !stall && !flush;

  // Carry out of the outermost counter marks the final iteration of the nest.
  affine_ctrl_counter #(.WIDTH(WIDTH), .EXT(EXT_2)) u_cnt_2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .inc_i   (issue),
    .count_o (cnt_2),
    .carry_o (carry_2)
  );

  affine_ctrl_counter #(.WIDTH(WIDTH), .EXT(EXT_1)) u_cnt_1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .inc_i   (carry_2),
    .count_o (cnt_1),
    .carry_o (carry_1)
  );

  affine_ctrl_counter #(.WIDTH(WIDTH), .EXT(EXT_0)) u_cnt_0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .inc_i   (carry_1),
    .count_o (cnt_0),
    .carry_o (carry_0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      delay_q <= '0;
      ii_q    <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cv_q    <= '0;
    end else if (flush) begin
      state_q <= DELAY;
      delay_q <= DELAY_LD;
      ii_q    <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cv_q    <= '0;
    end else begin
      en_q <= issue;
      if (issue) begin
        cv_q <= {cnt_2, cnt_1, cnt_0};
        ii_q <= II_M1;
      end
      case (state_q)
        DELAY: begin
          if (!stall) begin
            if (delay_q == '0) begin
              state_q <= carry_0 ? DONE : RUN;
            end else begin
              delay_q <= delay_q - 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            if (ii_q == '0) begin
              if (carry_0) begin
                state_q <= DONE;
              end
            end else begin
              ii_q <= ii_q - 1'b1;
            end
          end
        end
        DONE: begin
          // Entered together with the last en, so done rises one cycle after it.
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign en        = en_q;
  assign done      = done_q;
  assign ctrl_vars = cv_q;

`ifdef AFFINE_CTRL_ADDR_EN
  logic [WIDTH-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (flush) begin
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= WIDTH'(32'(cnt_1 >> SHIFT_1) * ROW_STRIDE + 32'(cnt_2 >> SHIFT_2));
    end
  end

  assign addr = addr_q;
`else
  if (SHIFT_1 < 0 || SHIFT_2 < 0 || ROW_STRIDE < 0) begin : g_bad_addr_cfg
    $error("affine_loop_ctrl: SHIFT_n and ROW_STRIDE must be non-negative");
  end
`endif

endmodule

// File: tb/tb_affine_loop_ctrl.sv
// tb/tb_affine_loop_ctrl.sv - randomized, model-checked bench for affine_loop_ctrl
module tb_affine_loop_ctrl;
  import affine_ctrl_pkg::*;

  localparam int NI        = 4;
  localparam int P_E0 [NI] = '{1, 1, 1, 2};
  localparam int P_E1 [NI] = '{128, 128, 2, 3};
  localparam int P_E2 [NI] = '{128, 128, 2, 4};
  localparam int P_II [NI] = '{1, 1, 3, 2};
  localparam int P_SD [NI] = '{0, 0, 5, 3};
  localparam int RST_EDGE  = 33000;
  localparam int END_EDGE  = 33300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_r [NI];
  logic       stall_r [NI];
  logic       en_w    [NI];
  logic       done_w  [NI];
  ctrl_vars_t cv_w    [NI];
`ifdef AFFINE_CTRL_ADDR_EN
  logic [15:0] addr_w   [NI];
  int          exp_addr [NI];
`endif

  int m_wait [NI];
  int m_n    [NI];
  int pc     [NI];
  bit m_act  [NI];
  bit m_lastp[NI];
  bit exp_en [NI];
  bit exp_done[NI];
  int exp_cv [NI][3];

  int nchk  = 0;
  int nfail = 0;
  int cur_e = -1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    affine_loop_ctrl #(
      .WIDTH       (DEFAULT_WIDTH),
      .EXT_0       (P_E0[g]),
      .EXT_1       (P_E1[g]),
      .EXT_2       (P_E2[g]),
      .II          (P_II[g]),
      .START_DELAY (P_SD[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_r[g]),
      .stall     (stall_r[g]),
      .en        (en_w[g]),
      .ctrl_vars (cv_w[g]),
      .done      (done_w[g])
`ifdef AFFINE_CTRL_ADDR_EN
      ,
      .addr      (addr_w[g])
`endif
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cur_e, act, exp);
    end
  endtask

  task automatic chk_it(input string nm, input int i, input int c0, input int c1, input int c2);
    chk({nm, ".en"},  int'(en_w[i]), 1);
    chk({nm, ".cv0"}, int'(cv_w[i][0]), c0);
    chk({nm, ".cv1"}, int'(cv_w[i][1]), c1);
    chk({nm, ".cv2"}, int'(cv_w[i][2]), c2);
  endtask

  task automatic model_reset(input int i);
    m_act[i]    = 1'b0;
    m_lastp[i]  = 1'b0;
    m_wait[i]   = 0;
    m_n[i]      = 0;
    pc[i]       = 0;
    exp_en[i]   = 1'b0;
    exp_done[i] = 1'b0;
    for (int k = 0; k < 3; k++) exp_cv[i][k] = 0;
`ifdef AFFINE_CTRL_ADDR_EN
    exp_addr[i] = 0;
`endif
  endtask

  // Schedule view: the next iteration issues on the Nth unstalled edge, N = START_DELAY+1 then II;
  // iteration n of the nest has indices given by the mixed-radix digits of n.
  task automatic model_step(input int i);
    int tot;
    tot = P_E0[i] * P_E1[i] * P_E2[i];
    if (!rst_n) begin
      model_reset(i);
    end else begin
      exp_en[i] = 1'b0;
      if (flush_r[i]) begin
        m_act[i]    = 1'b1;
        m_lastp[i]  = 1'b0;
        m_wait[i]   = P_SD[i] + 1;
        m_n[i]      = 0;
        pc[i]       = 0;
        exp_done[i] = 1'b0;
        for (int k = 0; k < 3; k++) exp_cv[i][k] = 0;
`ifdef AFFINE_CTRL_ADDR_EN
        exp_addr[i] = 0;
`endif
      end else if (m_lastp[i]) begin
        m_lastp[i]  = 1'b0;
        exp_done[i] = 1'b1;
      end else if (m_act[i] && !stall_r[i]) begin
        m_wait[i]--;
        if (m_wait[i] == 0) begin
          exp_en[i]    = 1'b1;
          exp_cv[i][2] = m_n[i] % P_E2[i];
          exp_cv[i][1] = (m_n[i] / P_E2[i]) % P_E1[i];
          exp_cv[i][0] = m_n[i] / (P_E1[i] * P_E2[i]);
`ifdef AFFINE_CTRL_ADDR_EN
          exp_addr[i] = ((exp_cv[i][1] / 2) * 64 + exp_cv[i][2] / 2) % 65536;
`endif
          m_n[i]++;
          m_wait[i] = P_II[i];
          if (m_n[i] == tot) begin
            m_act[i]   = 1'b0;
            m_lastp[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare(input int i);
    if (en_w[i]) pc[i]++;
    chk($sformatf("dut%0d.en", i), int'(en_w[i]), int'(exp_en[i]));
    chk($sformatf("dut%0d.done", i), int'(done_w[i]), int'(exp_done[i]));
    for (int k = 0; k < 3; k++)
      chk($sformatf("dut%0d.cv%0d", i, k), int'(cv_w[i][k]), exp_cv[i][k]);
`ifdef AFFINE_CTRL_ADDR_EN
    chk($sformatf("dut%0d.addr", i), int'(addr_w[i]), exp_addr[i]);
`endif
  endtask

  task automatic drive(input int e);
    for (int i = 0; i < NI; i++) begin
      flush_r[i] = 1'b0;
      stall_r[i] = 1'b0;
    end
    flush_r[0] = (e == 10) || (e == 16410);
    stall_r[0] = (e >= 16420) && (e <= 16424);
    flush_r[1] = (e == 10) || (e == 500) || (e == 700) || (e == 32900) || (e == 33100);
    stall_r[1] = ((e >= 20) && (e <= 24)) || (e == 700);
    flush_r[2] = (e == 0) || ((e >= 100) && ($urandom_range(199) == 0));
    stall_r[2] = (e >= 100) && ($urandom_range(3) == 0);
    flush_r[3] = ($urandom_range(59) == 0);
    stall_r[3] = ($urandom_range(3) == 0);
    if (e == RST_EDGE + 3) rst_n = 1'b1;
  endtask

  task automatic literals(input int e);
    case (e)
      6:     chk_it("t2_it0", 2, 0, 0, 0);
      9:     chk_it("t2_it1", 2, 0, 0, 1);
      11:    chk_it("t1_first", 0, 0, 0, 0);
      12:    chk_it("t2_it2", 2, 0, 1, 0);
      15:    begin chk_it("t2_it3", 2, 0, 1, 1); chk("t2_done_early", int'(done_w[2]), 0); end
      16:    begin chk("t2_done", int'(done_w[2]), 1); chk("t2_pulses", pc[2], 4); end
      25:    chk_it("t3b_resume", 1, 0, 0, 9);
      139:   chk_it("t1_row1", 0, 0, 1, 0);
      500:   chk("t4_abort", int'(en_w[1]), 0);
      501:   begin chk_it("t4_restart", 1, 0, 0, 0); chk("t4_done", int'(done_w[1]), 0); end
      658: begin
        chk_it("t6_iter", 0, 0, 5, 7);
`ifdef AFFINE_CTRL_ADDR_EN
        chk("t6_addr", int'(addr_w[0]), 131);
`endif
      end
      701:   chk_it("t4_flush_stall", 1, 0, 0, 0);
      16394: begin chk_it("t1_last", 0, 0, 127, 127); chk("t1_done_early", int'(done_w[0]), 0); end
      16395: begin
        chk("t1_done", int'(done_w[0]), 1);
        chk("t1_en_off", int'(en_w[0]), 0);
        chk("t1_hold", int'(cv_w[0][2]), 127);
        chk("t1_pulses", pc[0], 16384);
      end
      16419: chk_it("t3_before", 0, 0, 0, 8);
      16425: chk_it("t3_resume", 0, 0, 0, 9);
      17085: begin chk("t4_done_end", int'(done_w[1]), 1); chk("t4_pulses", pc[1], 16384); end
      32799: chk("t3_done_early", int'(done_w[0]), 0);
      32800: begin chk("t3_done", int'(done_w[0]), 1); chk("t3_pulses", pc[0], 16384); end
      33099: chk("t5_quiet", pc[1], 0);
      33101: chk_it("t5_reflush", 1, 0, 0, 0);
      default: ;
    endcase
    if (e >= 20 && e <= 24) chk("t3b_stalled", int'(en_w[1]), 0);
    if (e >= 16420 && e <= 16424) chk("t3_stalled", int'(en_w[0]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      flush_r[i] = 1'b0;
      stall_r[i] = 1'b0;
      model_reset(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) compare(i);
    rst_n = 1'b1;

    for (int e = 0; e <= END_EDGE; e++) begin
      drive(e);
      @(posedge clk);
      cur_e = e;
      for (int i = 0; i < NI; i++) model_step(i);
      if (e == RST_EDGE) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_en", int'(en_w[1]), 0);
        chk("t5_rst_done", int'(done_w[1]), 0);
        chk("t5_rst_cv2", int'(cv_w[1][2]), 0);
        for (int i = 0; i < NI; i++) model_reset(i);
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) compare(i);
      literals(e);
    end

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
